// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 share controller: operand widths,
// controller state encoding and FIPS-197 known-answer vectors.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = 128;

    // Controller states: idle/arbitrating, settling the core, holding a response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } aes_state_e;

    // FIPS-197 Appendix C.1 AES-128 example
    localparam logic [AES_KEY_W-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [AES_BLK_W-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [AES_BLK_W-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from the request
// vector and a priority pointer (last granted id); the pointer only moves
// when the caller reports that the granted request was accepted.
module aes_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant_valid,
    output logic       grant_id
);

    logic rr_last;

    // Grant: a lone requester wins; under contention the one not granted last wins
    always_comb begin
        grant_valid = req[0] | req[1];
        grant_id    = 1'b0;
        if (req[0] && req[1]) begin
            grant_id = ~rr_last;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
    end

    // Pointer starts at 1 so requester 0 wins the first contended grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (accept) begin
            rr_last <= grant_id;
        end
    end

endmodule

// File: rtl/aes128_share_ctrl.sv
// Shares one combinational AES-128 core between two requesters. Handshakes
// on both request ports and the response port are valid/ready: a transfer
// happens at a rising edge where valid and ready are both high; ready may
// depend on valid, valid never depends on ready. Operands are registered on
// accept and held until the next accept, so core_in/core_key/core_inv are
// stable for the whole settle window and the core can be timed as a
// multicycle path of SETTLE_CYCLES clocks.
module aes128_share_ctrl
    import aes_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [AES_BLK_W-1:0] req0_data,
    input  logic [AES_KEY_W-1:0] req0_key,
    input  logic                 req0_inv,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [AES_BLK_W-1:0] req1_data,
    input  logic [AES_KEY_W-1:0] req1_key,
    input  logic                 req1_inv,
    output logic [AES_BLK_W-1:0] core_in,
    output logic [AES_KEY_W-1:0] core_key,
    output logic                 core_inv,
    input  logic [AES_BLK_W-1:0] core_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [AES_BLK_W-1:0] rsp_data,
    output logic                 rsp_id,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_RESP = RESP;

    // Settle count loaded on accept; capture happens when it reaches zero,
    // which lands the capture SETTLE_CYCLES edges after the accept edge.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             grant_valid;
    logic             grant_id;
    logic             accept;

    aes_rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         ({req1_valid, req0_valid}),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Ready only for the granted requester and only while idle
    always_comb begin
        req0_ready = (state == ST_IDLE) && grant_valid && !grant_id;
        req1_ready = (state == ST_IDLE) && grant_valid &&  grant_id;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        busy       = (state != ST_IDLE);
    end

    // Operation sequencer: launch operands, count out the settle window,
    // capture the core result and hold it until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            core_in   <= '0;
            core_key  <= '0;
            core_inv  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        core_in  <= grant_id ? req1_data : req0_data;
                        core_key <= grant_id ? req1_key  : req0_key;
                        core_inv <= grant_id ? req1_inv  : req0_inv;
                        rsp_id   <= grant_id;
                        cnt      <= CNT_LOAD;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        rsp_data  <= core_out;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
